// File: rtl/ram_pkg.sv
// Shared types and helpers for the byte-enabled dual-port RAM.
// Lane merging is written against a wide ceiling so any word width up to MAX_DATA_W can reuse it.
package ram_pkg;

  typedef enum logic {
    RDW_READ_FIRST  = 1'b0,
    RDW_WRITE_FIRST = 1'b1
  } rdw_mode_e;

  localparam int MAX_DATA_W = 1024;

  function automatic int num_lanes(input int data_w, input int byte_w);
    return data_w / byte_w;
  endfunction

  // Bit i takes new_word when its lane (i / byte_w) is enabled, else keeps old_word.
  function automatic logic [MAX_DATA_W-1:0] lane_merge(
    input logic [MAX_DATA_W-1:0] old_word,
    input logic [MAX_DATA_W-1:0] new_word,
    input logic [MAX_DATA_W-1:0] be,
    input int                    byte_w
  );
    logic [MAX_DATA_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      if (be[i / byte_w]) begin
        merged[i] = new_word[i];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/ram_out_stage.sv
// Optional read-data output register (data + valid); adds one cycle when OUT_REG != 0.
// No backpressure: data is captured only when in_vld is high, otherwise the last value holds.
module ram_out_stage
  import ram_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int OUT_REG = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_dat,
  input  logic             in_vld,
  output logic [WIDTH-1:0] out_dat,
  output logic             out_vld
);

  if (OUT_REG != 0) begin : g_reg
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        out_dat <= '0;
        out_vld <= 1'b0;
      end else begin
        out_vld <= in_vld;
        if (in_vld) begin
          out_dat <= in_dat;
        end
      end
    end
  end else begin : g_pass
    // Clock and reset are intentionally unused in the pass-through build.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset_n;
    assign out_dat = in_dat;
    assign out_vld = in_vld;
  end

endmodule

// File: rtl/ram_2port_be.sv
// Single-clock true dual-port RAM with byte enables, A-wins write collisions and selectable RDW.
// Read latency OUT_REG+1 cycles, one access per port per cycle, no backpressure.
module ram_2port_be
  import ram_pkg::*;
#(
  parameter int        ADDR_WIDTH = 10,
  parameter int        DATA_WIDTH = 32,
  parameter int        BYTE_WIDTH = 8,
  parameter rdw_mode_e RDW_MODE   = RDW_READ_FIRST,
  parameter int        OUT_REG    = 0,
  localparam int       NUM_LANES  = num_lanes(DATA_WIDTH, BYTE_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,

  input  logic                  a_en,
  input  logic                  a_we,
  input  logic [NUM_LANES-1:0]  a_be,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_din,
  output logic [DATA_WIDTH-1:0] a_dout,
  output logic                  a_valid,

  input  logic                  b_en,
  input  logic                  b_we,
  input  logic [NUM_LANES-1:0]  b_be,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_din,
  output logic [DATA_WIDTH-1:0] b_dout,
  output logic                  b_valid,

  output logic                  collision
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  function automatic logic [DATA_WIDTH-1:0] merge(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [NUM_LANES-1:0]  be
  );
    return DATA_WIDTH'(lane_merge(MAX_DATA_W'(old_word), MAX_DATA_W'(new_word),
                                  MAX_DATA_W'(be), BYTE_WIDTH));
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  a_wr, b_wr;
  logic                  both_wr;
  logic [DATA_WIDTH-1:0] a_old, b_old;
  logic [DATA_WIDTH-1:0] a_solo, b_solo, both_word;
  logic [DATA_WIDTH-1:0] a_wdata, b_wdata;
  logic [DATA_WIDTH-1:0] a_rdata, b_rdata;

  logic [DATA_WIDTH-1:0] a_rd_q, b_rd_q;
  logic                  a_vld_q, b_vld_q;

  // A write with no lanes enabled degenerates to a plain read.
  assign a_wr    = a_en & a_we & (|a_be);
  assign b_wr    = b_en & b_we & (|b_be);
  assign both_wr = a_wr & b_wr & (a_addr == b_addr);

  assign a_old   = mem[a_addr];
  assign b_old   = mem[b_addr];

  assign a_solo  = merge(a_old, a_din, a_be);
  assign b_solo  = merge(b_old, b_din, b_be);
  // Layer A over B so lanes enabled by both ports end up with A's data.
  assign both_word = merge(b_solo, a_din, a_be);

  assign a_wdata = both_wr ? both_word : a_solo;
  assign b_wdata = both_wr ? both_word : b_solo;

  // Write-first only affects the writing port; a pure reader always sees the old word.
  always_comb begin
    a_rdata = a_old;
    b_rdata = b_old;
    if (RDW_MODE == RDW_WRITE_FIRST) begin
      if (a_wr) a_rdata = a_wdata;
      if (b_wr) b_rdata = b_wdata;
    end
  end

  // Both ports carry the identical word on a same-address write, so write order is irrelevant.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (a_wr) mem[a_addr] <= a_wdata;
      if (b_wr) mem[b_addr] <= b_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_rd_q    <= '0;
      b_rd_q    <= '0;
      a_vld_q   <= 1'b0;
      b_vld_q   <= 1'b0;
      collision <= 1'b0;
    end else begin
      a_vld_q   <= a_en;
      b_vld_q   <= b_en;
      if (a_en) a_rd_q <= a_rdata;
      if (b_en) b_rd_q <= b_rdata;
      collision <= both_wr & (|(a_be & b_be));
    end
  end

  ram_out_stage #(
    .WIDTH   (DATA_WIDTH),
    .OUT_REG (OUT_REG)
  ) u_out_a (
    .clk     (clk),
    .reset_n (reset_n),
    .in_dat  (a_rd_q),
    .in_vld  (a_vld_q),
    .out_dat (a_dout),
    .out_vld (a_valid)
  );

  ram_out_stage #(
    .WIDTH   (DATA_WIDTH),
    .OUT_REG (OUT_REG)
  ) u_out_b (
    .clk     (clk),
    .reset_n (reset_n),
    .in_dat  (b_rd_q),
    .in_vld  (b_vld_q),
    .out_dat (b_dout),
    .out_vld (b_valid)
  );

endmodule

// File: tb/tb_ram_2port_be.sv
// Drives one stimulus stream into two RAM builds: latency-1 read-first and latency-2 write-first.
module tb_ram_2port_be;
  import ram_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        a_en, a_we, b_en, b_we;
  logic [3:0]  a_be, b_be;
  logic [9:0]  a_addr, b_addr;
  logic [31:0] a_din, b_din;

  logic [31:0] a0_dout, b0_dout, a1_dout, b1_dout;
  logic        a0_valid, b0_valid, a1_valid, b1_valid;
  logic        col0, col1;

  int total = 0;
  int bad   = 0;

  ram_2port_be #(
    .ADDR_WIDTH (10), .DATA_WIDTH (32), .BYTE_WIDTH (8),
    .RDW_MODE (RDW_READ_FIRST), .OUT_REG (0)
  ) dut0 (
    .clk (clk), .reset_n (reset_n),
    .a_en (a_en), .a_we (a_we), .a_be (a_be), .a_addr (a_addr), .a_din (a_din),
    .a_dout (a0_dout), .a_valid (a0_valid),
    .b_en (b_en), .b_we (b_we), .b_be (b_be), .b_addr (b_addr), .b_din (b_din),
    .b_dout (b0_dout), .b_valid (b0_valid),
    .collision (col0)
  );

  ram_2port_be #(
    .ADDR_WIDTH (10), .DATA_WIDTH (32), .BYTE_WIDTH (8),
    .RDW_MODE (RDW_WRITE_FIRST), .OUT_REG (1)
  ) dut1 (
    .clk (clk), .reset_n (reset_n),
    .a_en (a_en), .a_we (a_we), .a_be (a_be), .a_addr (a_addr), .a_din (a_din),
    .a_dout (a1_dout), .a_valid (a1_valid),
    .b_en (b_en), .b_we (b_we), .b_be (b_be), .b_addr (b_addr), .b_din (b_din),
    .b_dout (b1_dout), .b_valid (b1_valid),
    .collision (col1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    a_en = 1'b0; a_we = 1'b0; a_be = 4'h0; a_addr = 10'd0; a_din = 32'h0;
    b_en = 1'b0; b_we = 1'b0; b_be = 4'h0; b_addr = 10'd0; b_din = 32'h0;
  endtask

  task automatic pa(input logic we, input logic [3:0] be, input logic [9:0] addr,
                    input logic [31:0] din);
    a_en = 1'b1; a_we = we; a_be = be; a_addr = addr; a_din = din;
  endtask

  task automatic pb(input logic we, input logic [3:0] be, input logic [9:0] addr,
                    input logic [31:0] din);
    b_en = 1'b1; b_we = we; b_be = be; b_addr = addr; b_din = din;
  endtask

  // After step(), dut0 shows this step's access and dut1 shows the previous step's.
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("rst_a0_dout", a0_dout, 32'h0);
    chk("rst_b0_dout", b0_dout, 32'h0);
    chk("rst_a0_vld", {31'b0, a0_valid}, 32'h0);
    chk("rst_b0_vld", {31'b0, b0_valid}, 32'h0);
    chk("rst_col0", {31'b0, col0}, 32'h0);
    chk("rst_a1_dout", a1_dout, 32'h0);
    chk("rst_b1_dout", b1_dout, 32'h0);
    chk("rst_a1_vld", {31'b0, a1_valid}, 32'h0);
    chk("rst_b1_vld", {31'b0, b1_valid}, 32'h0);
    chk("rst_col1", {31'b0, col1}, 32'h0);
    reset_n = 1'b1;

    // First access right after release
    pa(1'b1, 4'hF, 10'd5, 32'hDEADBEEF); step();
    chk("first_a0_vld", {31'b0, a0_valid}, 32'h1);
    chk("first_a1_vld_early", {31'b0, a1_valid}, 32'h0);

    pb(1'b0, 4'h0, 10'd5, 32'h0); step();
    chk("rd5_b0_vld", {31'b0, b0_valid}, 32'h1);
    chk("rd5_b0_dout", b0_dout, 32'hDEADBEEF);
    chk("idle_a0_vld", {31'b0, a0_valid}, 32'h0);
    chk("wf5_a1_vld", {31'b0, a1_valid}, 32'h1);
    chk("wf5_a1_dout", a1_dout, 32'hDEADBEEF);

    pa(1'b1, 4'hF, 10'd7, 32'h11223344); step();
    chk("rd5_b1_vld", {31'b0, b1_valid}, 32'h1);
    chk("rd5_b1_dout", b1_dout, 32'hDEADBEEF);
    chk("hold_b0_vld", {31'b0, b0_valid}, 32'h0);
    chk("hold_b0_dout", b0_dout, 32'hDEADBEEF);

    // Byte-enable merge on addr 7
    pa(1'b1, 4'b0101, 10'd7, 32'hAABBCCDD); step();
    chk("be_rf_a0_old", a0_dout, 32'h11223344);
    chk("init7_a1", a1_dout, 32'h11223344);

    pa(1'b0, 4'h0, 10'd7, 32'h0); pb(1'b1, 4'hF, 10'd9, 32'h0); step();
    chk("be_rd_a0", a0_dout, 32'h11BB33DD);
    chk("be_wf_a1", a1_dout, 32'h11BB33DD);

    // Same-port RDW on addr 9, plus B seeds addr 3
    pa(1'b1, 4'b0011, 10'd9, 32'h12345678); pb(1'b1, 4'hF, 10'd3, 32'hCAFE0000); step();
    chk("rdw_rf_a0", a0_dout, 32'h0);
    chk("be_rd_a1", a1_dout, 32'h11BB33DD);
    chk("init9_b1", b1_dout, 32'h0);

    // Cross-port RDW on addr 3
    pa(1'b1, 4'hF, 10'd3, 32'h0000BABE); pb(1'b0, 4'h0, 10'd3, 32'h0); step();
    chk("xrdw_b0_old", b0_dout, 32'hCAFE0000);
    chk("xrdw_a0_old", a0_dout, 32'hCAFE0000);
    chk("rdw_wf_a1", a1_dout, 32'h00005678);
    chk("init3_b1", b1_dout, 32'hCAFE0000);

    pa(1'b0, 4'h0, 10'd9, 32'h0); pb(1'b0, 4'h0, 10'd3, 32'h0); step();
    chk("xrdw_b0_new", b0_dout, 32'h0000BABE);
    chk("rd9_a0", a0_dout, 32'h00005678);
    chk("xrdw_b1_old", b1_dout, 32'hCAFE0000);
    chk("xrdw_a1_wf", a1_dout, 32'h0000BABE);

    // Collision on addr 20: lane 0 must keep 0x78
    pa(1'b1, 4'hF, 10'd20, 32'h12345678); step();
    chk("xrdw_b1_new", b1_dout, 32'h0000BABE);
    chk("rd9_a1", a1_dout, 32'h00005678);
    chk("nocol_single", {31'b0, col0}, 32'h0);

    pa(1'b1, 4'b1100, 10'd20, 32'hAAAAAAAA); pb(1'b1, 4'b0110, 10'd20, 32'hBBBBBBBB); step();
    chk("col0_pulse", {31'b0, col0}, 32'h1);
    chk("col1_pulse", {31'b0, col1}, 32'h1);
    chk("col_a0_rf", a0_dout, 32'h12345678);
    chk("col_b0_rf", b0_dout, 32'h12345678);
    chk("init20_a1", a1_dout, 32'h12345678);

    pa(1'b0, 4'h0, 10'd20, 32'h0); step();
    chk("col0_end", {31'b0, col0}, 32'h0);
    chk("col1_end", {31'b0, col1}, 32'h0);
    chk("col_word_a0", a0_dout, 32'hAAAABB78);
    chk("col_a1_wf", a1_dout, 32'hAAAABB78);
    chk("col_b1_wf", b1_dout, 32'hAAAABB78);

    pa(1'b1, 4'b1100, 10'd20, 32'h11111111); pb(1'b1, 4'b0011, 10'd20, 32'h22222222); step();
    chk("disjoint_col0", {31'b0, col0}, 32'h0);
    chk("disjoint_col1", {31'b0, col1}, 32'h0);
    chk("disjoint_a0_rf", a0_dout, 32'hAAAABB78);

    pb(1'b0, 4'h0, 10'd20, 32'h0); step();
    chk("disjoint_b0", b0_dout, 32'h11112222);
    chk("disjoint_a1_wf", a1_dout, 32'h11112222);
    chk("disjoint_b1_wf", b1_dout, 32'h11112222);

    // Address extremes 0 and 1023
    pa(1'b1, 4'hF, 10'd0, 32'h0F0F0F0F); pb(1'b1, 4'hF, 10'd1023, 32'h5A5A5A5A); step();
    pa(1'b0, 4'h0, 10'd1023, 32'h0); pb(1'b0, 4'h0, 10'd0, 32'h0); step();
    chk("top_a0", a0_dout, 32'h5A5A5A5A);
    chk("zero_b0", b0_dout, 32'h0F0F0F0F);
    chk("zero_a1_wf", a1_dout, 32'h0F0F0F0F);
    chk("top_b1_wf", b1_dout, 32'h5A5A5A5A);
    step();
    chk("top_a1", a1_dout, 32'h5A5A5A5A);
    chk("zero_b1", b1_dout, 32'h0F0F0F0F);

    // Reset in the middle of back-to-back reads
    pa(1'b0, 4'h0, 10'd5, 32'h0); step();
    chk("b2b_a0_5", a0_dout, 32'hDEADBEEF);
    pa(1'b0, 4'h0, 10'd7, 32'h0); step();
    chk("b2b_a0_7", a0_dout, 32'h11BB33DD);
    chk("b2b_a1_vld", {31'b0, a1_valid}, 32'h1);
    chk("b2b_a1_5", a1_dout, 32'hDEADBEEF);
    pa(1'b0, 4'h0, 10'd9, 32'h0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_a0_vld", {31'b0, a0_valid}, 32'h0);
    chk("mid_rst_a1_vld", {31'b0, a1_valid}, 32'h0);
    chk("mid_rst_a1_dout", a1_dout, 32'h0);
    step();
    reset_n = 1'b1;
    step();
    chk("post_rst_a0_vld", {31'b0, a0_valid}, 32'h0);
    chk("post_rst_a1_vld", {31'b0, a1_valid}, 32'h0);
    step();
    chk("post_rst_a1_vld2", {31'b0, a1_valid}, 32'h0);

    pa(1'b0, 4'h0, 10'd7, 32'h0); step();
    chk("reread_a0_vld", {31'b0, a0_valid}, 32'h1);
    chk("reread_a0", a0_dout, 32'h11BB33DD);
    chk("reread_a1_early", {31'b0, a1_valid}, 32'h0);
    step();
    chk("reread_a1_vld", {31'b0, a1_valid}, 32'h1);
    chk("reread_a1", a1_dout, 32'h11BB33DD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
